// File: rtl/llr_loader.sv
// rtl/llr_loader.sv - LLR quantizer and two-bank ping-pong frame assembler for the LDPC decoder
module llr_loader #(
  parameter int data_w  = 5,
  parameter int in_w    = 8,
  parameter int shift_f = 2,
  parameter int R       = 24,
  parameter int D       = 96,
  parameter int P       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [P*in_w-1:0]       s_data,
  input  logic                    s_last,
  output logic [R*D*data_w-1:0]   sig,
  output logic                    sig_valid,
  input  logic                    take,
  output logic                    frame_err,
  output logic [1:0]              frames_buf
);

  localparam int N      = R * D;
  localparam int BEATS  = N / P;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BANK_W = N * data_w;
  localparam int OFF_W  = $clog2(BANK_W);
  localparam int BEAT_W = P * data_w;
  localparam int QMAX   = (1 << (data_w - 1)) - 1;

  logic [BANK_W-1:0] bank_q [2];
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              frame_err_q, frame_err_d;

  logic [BEAT_W-1:0] wdata;
  logic [OFF_W-1:0]  wr_off;
  logic              accept;
  logic              last_slot;
  logic              take_ok;

  // Floor shift then clamp to the symmetric range; the most negative code is never emitted.
  function automatic logic [data_w-1:0] quant(input logic [in_w-1:0] x);
    logic signed [in_w-1:0] t;
    logic signed [31:0]     tw;
    logic signed [31:0]     qm;
    t  = $signed(x) >>> shift_f;
    tw = {{(32-in_w){t[in_w-1]}}, t};
    qm = QMAX;
    if (tw > qm) begin
      tw = qm;
    end else if (tw < -qm) begin
      tw = -qm;
    end
    return tw[data_w-1:0];
  endfunction

  assign s_ready    = ~full_q[wr_sel_q];
  assign sig        = bank_q[rd_sel_q];
  assign sig_valid  = full_q[rd_sel_q];
  assign frame_err  = frame_err_q;
  assign frames_buf = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  assign accept    = s_valid && s_ready;
  assign last_slot = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign take_ok   = take && full_q[rd_sel_q];
  assign wr_off    = OFF_W'(beat_cnt_q) * OFF_W'(BEAT_W);

  // Quantize all P samples of the incoming beat in parallel.
  always_comb begin
    wdata = '0;
    for (int p = 0; p < P; p++) begin
      wdata[p*data_w +: data_w] = quant(s_data[p*in_w +: in_w]);
    end
  end

  // Next-state: beat counting, frame commit/abort on the write side, bank release on the read side.
  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    beat_cnt_d  = beat_cnt_q;
    frame_err_d = 1'b0;
    if (accept) begin
      if (last_slot) begin
        // A full count always commits; a missing s_last is only flagged.
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        beat_cnt_d       = '0;
        frame_err_d      = ~s_last;
      end else if (s_last) begin
        // Early s_last: drop the partial frame and restart in the same bank.
        beat_cnt_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    // A write needs its bank empty and a take needs its bank full, so these never hit the same bit.
    if (take_ok) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  // Control registers; reset discards any partial frame and empties both banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Bank storage needs no reset: contents only matter once the full flag is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[wr_sel_q][wr_off +: BEAT_W] <= wdata;
    end
  end

endmodule

// File: tb/tb_llr_loader.sv
// tb/tb_llr_loader.sv - directed self-checking bench for llr_loader
module tb_llr_loader;

  localparam int DW    = 5;
  localparam int IW    = 8;
  localparam int SHF   = 2;
  localparam int R     = 24;
  localparam int D     = 96;
  localparam int P     = 8;
  localparam int N     = R * D;
  localparam int BEATS = N / P;
  localparam int QM    = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [P*IW-1:0]      s_data = '0;
  logic                 s_last = 1'b0;
  logic [N*DW-1:0]      sig;
  logic                 sig_valid;
  logic                 take = 1'b0;
  logic                 frame_err;
  logic [1:0]           frames_buf;

  int tests_run = 0;
  int tests_failed = 0;

  int sweep_in [8]  = '{37, 100, -128, -1, 3, -61, 63, -4};
  int sweep_exp [8] = '{9, 15, -15, -1, 0, -15, 15, -1};

  llr_loader #(
    .data_w(DW), .in_w(IW), .shift_f(SHF), .R(R), .D(D), .P(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .sig(sig),
    .sig_valid(sig_valid),
    .take(take),
    .frame_err(frame_err),
    .frames_buf(frames_buf)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected quantizer: floor division by 2^SHF, then symmetric clamp.
  function automatic int qmodel(input int x);
    int div;
    int t;
    div = 1 << SHF;
    if (x >= 0) t = x / div;
    else t = -((-x + div - 1) / div);
    if (t > QM) t = QM;
    if (t < -QM) t = -QM;
    return t;
  endfunction

  function automatic int gen(input int f, input int n);
    if (f == 0 && n < 8) return sweep_in[n];
    return ((n * 37 + f * 53 + (n >> 3) * 11) % 256) - 128;
  endfunction

  function automatic int sig_at(input int n);
    logic signed [DW-1:0] s;
    s = sig[n*DW +: DW];
    return int'(s);
  endfunction

  task automatic check_frame(input string tag, input int f);
    int mism;
    mism = 0;
    for (int n = 0; n < N; n++) begin
      if (sig_at(n) != qmodel(gen(f, n))) mism++;
    end
    chk(tag, mism, 0);
  endtask

  // Called at a negedge; holds the beat until accepted, returns at the negedge after transfer.
  task automatic send_beat(input logic [P*IW-1:0] d, input logic l);
    int guard;
    guard = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("beat_wait", int'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int f, input int b0, input int b1, input int last_at, input bit take_last);
    logic [P*IW-1:0] d;
    for (int b = b0; b <= b1; b++) begin
      for (int p = 0; p < P; p++) d[p*IW +: IW] = 8'(gen(f, b*P + p));
      if (take_last && b == b1) take = 1'b1;
      send_beat(d, b == last_at);
      take = 1'b0;
    end
  endtask

  task automatic take_pulse();
    take = 1'b1;
    @(negedge clk);
    take = 1'b0;
  endtask

  initial begin
    logic [P*IW-1:0] d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_sig_valid", int'(sig_valid), 0);
    chk("rst_frames_buf", int'(frames_buf), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_frame_err", int'(frame_err), 0);

    // single frame with quantization sweep in the first beat
    send_frame(0, 0, BEATS-2, BEATS-1, 1'b0);
    chk("pre_last_sig_valid", int'(sig_valid), 0);
    send_frame(0, BEATS-1, BEATS-1, BEATS-1, 1'b0);
    chk("single_sig_valid", int'(sig_valid), 1);
    chk("single_frames_buf", int'(frames_buf), 1);
    chk("single_s_ready", int'(s_ready), 1);
    chk("single_frame_err", int'(frame_err), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("sweep_%0d", i), sig_at(i), sweep_exp[i]);
    check_frame("single_frame", 0);

    // back-pressure: second frame fills bank1, third stalls
    send_frame(1, 0, BEATS-1, BEATS-1, 1'b0);
    chk("bp_frames_buf2", int'(frames_buf), 2);
    chk("bp_s_ready0", int'(s_ready), 0);
    check_frame("bp_sig_f0", 0);
    for (int p = 0; p < P; p++) d[p*IW +: IW] = 8'(gen(2, p));
    s_data = d; s_last = 1'b0; s_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_stall_ready", int'(s_ready), 0);
    chk("bp_stall_buf", int'(frames_buf), 2);
    take_pulse();
    chk("bp_ready_after_take", int'(s_ready), 1);
    chk("bp_buf_after_take", int'(frames_buf), 1);
    chk("bp_sig_valid", int'(sig_valid), 1);
    check_frame("bp_sig_f1", 1);
    send_frame(2, 0, BEATS-1, BEATS-1, 1'b0);
    chk("bp_frames_buf_end", int'(frames_buf), 2);
    check_frame("bp_sig_f1_hold", 1);

    // simultaneous take and frame commit
    take_pulse();
    chk("sim_pre_buf", int'(frames_buf), 1);
    check_frame("sim_pre_sig", 2);
    send_frame(3, 0, BEATS-1, BEATS-1, 1'b1);
    chk("sim_frames_buf", int'(frames_buf), 1);
    chk("sim_sig_valid", int'(sig_valid), 1);
    check_frame("sim_sig_f3", 3);

    // early s_last on beat 100
    send_frame(4, 0, 100, 100, 1'b0);
    chk("early_err_pulse", int'(frame_err), 1);
    @(negedge clk);
    chk("early_err_clear", int'(frame_err), 0);
    chk("early_buf", int'(frames_buf), 1);
    send_frame(5, 0, BEATS-1, BEATS-1, 1'b0);
    chk("early_next_buf", int'(frames_buf), 2);
    chk("early_next_err", int'(frame_err), 0);
    take_pulse();
    check_frame("early_next_frame", 5);

    // missing s_last on final beat
    send_frame(6, 0, BEATS-1, -1, 1'b0);
    chk("nolast_err_pulse", int'(frame_err), 1);
    chk("nolast_buf", int'(frames_buf), 2);
    @(negedge clk);
    chk("nolast_err_clear", int'(frame_err), 0);
    take_pulse();
    check_frame("nolast_frame", 6);

    // asynchronous reset mid-frame with one bank full
    send_frame(7, 0, 150, -1, 1'b0);
    chk("mid_pre_buf", int'(frames_buf), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sig_valid", int'(sig_valid), 0);
    chk("mid_rst_buf", int'(frames_buf), 0);
    chk("mid_rst_ready", int'(s_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8, 0, BEATS-1, BEATS-1, 1'b0);
    chk("post_rst_buf", int'(frames_buf), 1);
    chk("post_rst_valid", int'(sig_valid), 1);
    check_frame("post_rst_frame", 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/llr_loader.md
Name: llr_loader

Overview:
- Upstream feeder for the LDPC decoder core.
- Accepts a stream of wide channel LLR samples over a valid/ready handshake, then quantizes and saturates each sample to data_w bits.
- Assembles whole R*D-sample codeword frames in a two-bank ping-pong buffer and presents the packed frame on a wide bus in the decoder's sig layout.
- The decoder-side controller pulses take when the core latches sig, which frees the bank.

Parameters:
- data_w, 5, output LLR width (signed two's complement)
- in_w, 8, input sample width (signed)
- shift_f, 2, fractional bits dropped by arithmetic right shift before saturation
- R, 24, block columns of the code
- D, 96, expansion factor; frame length N = R*D samples
- P, 8, samples per input beat; N must be divisible by P; BEATS = N/P (288 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  P*in_w  P samples; sample p at [p*in_w +: in_w]; lower p = lower frame index
- s_last  in  1  marks the final beat of a frame
- sig  out  R*D*data_w  packed frame; frame sample n at [n*data_w +: data_w]
- sig_valid  out  1  sig holds a complete frame
- take  in  1  consumer has latched sig; free the bank
- frame_err  out  1  one-cycle pulse on s_last misalignment
- frames_buf  out  2  number of full banks (0..2)

Behaviour:
- Beat transfer: a beat transfers when s_valid && s_ready at a rising edge.
- State:
  - bank0 and bank1, each N*data_w bits
  - full[1:0]
  - wr_sel and rd_sel, 1 bit each
  - beat_cnt, counting 0..BEATS-1
- Reset (async): full=0, wr_sel=0, rd_sel=0, beat_cnt=0, frame_err=0.
  - Bank contents are unspecified; sig is don't-care while sig_valid=0.
  - Reset mid-frame discards the partial frame and both banks.
- s_ready = ~full[wr_sel], combinational from registers. It does not depend on s_valid.
- Quantization, per sample x:
  - t = x >>> shift_f (arithmetic shift, floor toward -inf).
  - q = clamp(t, -(2^(data_w-1)-1), +(2^(data_w-1)-1)). The range is symmetric, ±15 at defaults; -16 is never produced.
- Write path: an accepted beat stores its P quantized samples at frame indices beat_cnt*P+p of bank[wr_sel]. beat_cnt then increments.
- Frame completion: on an accepted beat with beat_cnt==BEATS-1:
  - full[wr_sel] is set, wr_sel toggles, beat_cnt returns to 0.
  - If s_last=0 on that beat, the frame is still committed and frame_err pulses.
- Early s_last: s_last=1 on a beat with beat_cnt<BEATS-1:
  - The beat is accepted and discarded, along with the partial frame.
  - beat_cnt returns to 0, full and wr_sel are unchanged, frame_err pulses.
- Read path:
  - sig = bank[rd_sel].
  - sig_valid = full[rd_sel].
  - take && sig_valid: clear full[rd_sel] and toggle rd_sel.
  - take while sig_valid=0 is ignored.
- Output stability: sig and sig_valid are stable from the cycle sig_valid rises until the edge on which take is sampled.
- Latency:
  - The last beat accepted at edge k gives sig_valid=1 after edge k, if that bank is rd_sel.
  - A take at edge k raises s_ready after edge k, if the freed bank is wr_sel.
- Simultaneous events: frame completion into one bank and take from the other on the same edge both take effect. frames_buf is unchanged net.
  - wr_sel==rd_sel never yields a write/take conflict: a write requires the bank empty, a take requires it full.
- frames_buf = full[0]+full[1].
- frame_err is a registered one-cycle pulse and is 0 otherwise.

Test Plan:
- Quantization sweep (shift_f=2, data_w=5) -> required outputs:
  - s_data samples 37, 100, -128, -1, 3, -61, 63, -4
  - after a full frame, sig indices 0..7 = 9, 15, -15, -1, 0, -15, 15, -1
- Single frame: send 288 beats, s_last on beat 287, take held 0.
  - Required: sig_valid rises the cycle after beat 287.
  - Required: frames_buf=1, s_ready stays 1, index n holds the quantized sample n.
- Back-pressure: send 3 frames with take=0.
  - Required: frames_buf=2 after frame 2, and s_ready=0 from that point.
  - Required: the first beat of frame 3 stalls until a single take pulse. s_ready rises the next cycle, then frame 3 loads into bank0 while sig shows frame 2.
- Simultaneous: take asserted on the same edge as the last beat of the other bank.
  - Required: frames_buf stays 1, rd_sel toggles, and sig switches to the new frame.
- Misaligned s_last:
  - s_last on beat 100 -> frame_err pulse, partial frame dropped, next 288 beats form a valid frame.
  - missing s_last on beat 287 -> frame_err pulse and the frame is committed.
- Reset mid-frame: assert rst after beat 150 with one bank full.
  - Required: sig_valid=0, frames_buf=0, s_ready=1 immediately (asynchronous).
  - Required: a fresh frame loads correctly afterward.
